mips_cpu_reg_file: RTL and testbench
====================================

Name: mips_cpu_reg_file

Overview:
- 32 x 32-bit MIPS general-purpose register file for the multicycle Avalon-bus CPU core.
- Two combinational read ports, addressed by the rs and rt fields.
- One synchronous write port, addressed by rd or the destination selected by the controller.
- Register $zero is hardwired to 0; $v0 is exported for the top-level register_v0 debug output.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH = 32.

Ports:
Port order is fixed; the CPU core connects positionally in this order.
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears all registers while low.
- read_reg1  input  5  read port 1 index (rs).
- read_reg2  input  5  read port 2 index (rt).
- write_reg  input  5  write port index (rd or selected destination).
- write_data  input  32  data to write.
- write_enable  input  1  write strobe, sampled at the rising clk edge.
- read_data1  output  32  contents of register[read_reg1].
- read_data2  output  32  contents of register[read_reg2].
- register_v0  output  32  contents of register 2 ($v0), continuously driven.

Behaviour:
- Storage: 32 registers of DATA_WIDTH bits each.
- Reset:
  - reset low clears all 32 registers to 0x00000000 immediately, with no clock edge needed.
  - While reset is low, all outputs read 0 and writes are blocked.
  - Release is sampled normally: the first write can take effect on the first rising edge with reset high.
- Reads:
  - Purely combinational; read_data1 = reg[read_reg1] and read_data2 = reg[read_reg2], with zero latency.
  - An address change is reflected in the same cycle.
  - Both ports may address the same register and both return the same value.
- Write:
  - On rising clk with reset high and write_enable=1, reg[write_reg] <= write_data.
  - The new value is visible on the read ports after that edge.
  - With write_enable=0, no register changes.
- Register 0:
  - Writes to index 0 are ignored.
  - Reading index 0 always returns 0 on every port.
- Read-during-write to the same index: no bypass. The read port shows the old value until the edge, then the new value.
- register_v0: always equals reg[2] and follows the same write timing. It reads 0 after reset.
- Reset asserted mid-operation:
  - Overrides any write in the same cycle.
  - The register file contents are lost.
- Inputs are never X-propagated into storage when write_enable=0.

Decomposition:
- Shared package (alongside mips_cpu_definitions) holds:
  - REG_COUNT = 32
  - REG_ZERO = 5'd0
  - REG_V0 = 5'd2
  - REG_RA = 5'd31 (for the JAL/JALR link in the core)
- Leaf module with no sub-modules: one storage array, one async-reset write always block, and combinational read assigns.

Test Plan:
1. Reset: assert reset=0 mid-run after filling registers → all read_data and register_v0 are 0x00000000 immediately, without a clock edge. Release reset → every index 0..31 still reads 0.
2. Basic write/read: write 0xDEADBEEF to r5 → after the edge, read_reg1=5 gives 0xDEADBEEF. Write 0x12345678 to r31 → read_reg2=31 gives 0x12345678 while port 1 still gives 0xDEADBEEF.
3. $zero: write 0xFFFFFFFF to r0 with write_enable=1 → read_data1 and read_data2 at index 0 remain 0x00000000.
4. Write enable: set write_reg=7, write_data=0xAAAA5555, write_enable=0 for 3 cycles → r7 stays at its prior value (0 after reset).
5. Same-cycle read/write on r2: r2=0x00000001, then drive write of 0x00000002 with read_reg1=2 → before the edge read_data1=1; after the edge read_data1=2 and register_v0=2.
6. Sweep: write value i*0x01010101 to each r1..r31 on consecutive edges, then read all pairs (i, 31-i) → correct values on both ports, with index 0 returning 0.

Source files
------------

// File: rtl/mips_cpu_reg_file_pkg.sv
// Shared register-file constants for the multicycle MIPS core.
// Architectural register indices used by the core and the register file.
package mips_cpu_reg_file_pkg;

    localparam int unsigned REG_COUNT = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_V0   = 5'd2;
    localparam logic [4:0] REG_RA   = 5'd31;  // JAL/JALR link destination

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] reg_word_t;

endpackage

// File: rtl/mips_cpu_reg_file_if.sv
// Bundle of register-file port signals as seen from the core (master)
// and the register file (slave).
interface mips_cpu_reg_file_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);

    logic [ADDR_WIDTH-1:0] read_reg1;
    logic [ADDR_WIDTH-1:0] read_reg2;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic [DATA_WIDTH-1:0] register_v0;

    modport master (
        output read_reg1, read_reg2, write_reg, write_data, write_enable,
        input  read_data1, read_data2, register_v0
    );

    modport slave (
        input  read_reg1, read_reg2, write_reg, write_data, write_enable,
        output read_data1, read_data2, register_v0
    );

endinterface

// File: rtl/mips_cpu_reg_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one
// synchronous write port, $zero hardwired, $v0 exported for debug.
module mips_cpu_reg_file
    import mips_cpu_reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic [DATA_WIDTH-1:0] register_v0
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Index 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && (write_reg != ADDR_WIDTH'(REG_ZERO))) begin
            regs[write_reg] <= write_data;
        end
    end

    assign read_data1  = regs[read_reg1];
    assign read_data2  = regs[read_reg2];
    assign register_v0 = regs[ADDR_WIDTH'(REG_V0)];

endmodule

// File: tb/tb_mips_cpu_reg_file.sv
// Directed self-checking bench for mips_cpu_reg_file.
module tb_mips_cpu_reg_file;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mips_cpu_reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

    mips_cpu_reg_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .read_reg1    (rf.read_reg1),
        .read_reg2    (rf.read_reg2),
        .write_reg    (rf.write_reg),
        .write_data   (rf.write_data),
        .write_enable (rf.write_enable),
        .read_data1   (rf.read_data1),
        .read_data2   (rf.read_data2),
        .register_v0  (rf.register_v0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        rf.write_reg    = idx;
        rf.write_data   = data;
        rf.write_enable = 1'b1;
        @(posedge clk);
        #1;
        rf.write_enable = 1'b0;
    endtask

    task automatic read_pair(input logic [4:0] a, input logic [4:0] b);
        rf.read_reg1 = a;
        rf.read_reg2 = b;
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b0;
        rf.read_reg1    = '0;
        rf.read_reg2    = '0;
        rf.write_reg    = '0;
        rf.write_data   = '0;
        rf.write_enable = 1'b0;

        // Power-on reset state
        #2;
        read_pair(5'd2, 5'd31);
        check("por_rd1", rf.read_data1, 32'h0);
        check("por_rd2", rf.read_data2, 32'h0);
        check("por_v0", rf.register_v0, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Basic write/read
        do_write(5'd5, 32'hDEADBEEF);
        read_pair(5'd5, 5'd0);
        check("w_r5_p1", rf.read_data1, 32'hDEADBEEF);
        do_write(5'd31, 32'h12345678);
        read_pair(5'd5, 5'd31);
        check("w_r31_p2", rf.read_data2, 32'h12345678);
        check("w_r5_kept", rf.read_data1, 32'hDEADBEEF);

        // $zero ignores writes
        do_write(5'd0, 32'hFFFFFFFF);
        read_pair(5'd0, 5'd0);
        check("zero_p1", rf.read_data1, 32'h0);
        check("zero_p2", rf.read_data2, 32'h0);

        // Write enable low for three edges
        @(negedge clk);
        rf.write_reg    = 5'd7;
        rf.write_data   = 32'hAAAA5555;
        rf.write_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        read_pair(5'd7, 5'd7);
        check("we_low_r7", rf.read_data1, 32'h0);

        // Read-during-write on r2: no bypass
        do_write(5'd2, 32'h00000001);
        @(negedge clk);
        rf.write_reg    = 5'd2;
        rf.write_data   = 32'h00000002;
        rf.write_enable = 1'b1;
        rf.read_reg1    = 5'd2;
        #1;
        check("rdw_before", rf.read_data1, 32'h1);
        check("rdw_v0_before", rf.register_v0, 32'h1);
        @(posedge clk);
        #1;
        rf.write_enable = 1'b0;
        check("rdw_after", rf.read_data1, 32'h2);
        check("rdw_v0_after", rf.register_v0, 32'h2);

        // Sweep r1..r31 with i*0x01010101, then read pairs (i, 31-i)
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            read_pair(5'(i), 5'(31 - i));
            check($sformatf("sweep_p1_r%0d", i), rf.read_data1, 32'(i) * 32'h01010101);
            check($sformatf("sweep_p2_r%0d", 31 - i), rf.read_data2, 32'(31 - i) * 32'h01010101);
        end
        check("sweep_v0", rf.register_v0, 32'h02020202);

        // Mid-cycle reset with a pending write: clears immediately and blocks the write
        @(negedge clk);
        rf.write_reg    = 5'd3;
        rf.write_data   = 32'hCAFEF00D;
        rf.write_enable = 1'b1;
        #2;
        reset = 1'b0;
        read_pair(5'd31, 5'd5);
        check("rst_p1", rf.read_data1, 32'h0);
        check("rst_p2", rf.read_data2, 32'h0);
        check("rst_v0", rf.register_v0, 32'h0);
        @(posedge clk);
        #1;
        read_pair(5'd3, 5'd3);
        check("rst_blocks_wr", rf.read_data1, 32'h0);
        @(negedge clk);
        rf.write_enable = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            read_pair(5'(i), 5'(i));
            check($sformatf("post_rst_r%0d", i), rf.read_data1, 32'h0);
        end

        // First edge after release accepts a write
        do_write(5'd2, 32'h0000BEEF);
        check("post_rst_v0", rf.register_v0, 32'h0000BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
